// File: rtl/nn_pkg.sv
// Shared definitions for the inference controller: FSM states, result flag
// bit positions and default geometry of the network interface.
package nn_pkg;

    localparam int NN_NUM_INPUTS  = 42;
    localparam int NN_NUM_OUTPUTS = 7;
    localparam int NN_ACT_WIDTH   = 14;

    // Bit positions inside res_flags.
    localparam int FLAG_TIMEOUT  = 0;
    localparam int FLAG_NO_LEGAL = 1;

    localparam logic [1:0] FLAGS_NONE     = 2'b00;
    localparam logic [1:0] FLAGS_TIMEOUT  = 2'(1 << FLAG_TIMEOUT);
    localparam logic [1:0] FLAGS_NO_LEGAL = 2'(1 << FLAG_NO_LEGAL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_SCAN,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/masked_argmax_seq.sv
// Sequential masked argmax: walks one index per cycle after start, keeping
// the first legal entry and replacing it only on a strictly greater signed
// value, so ties stay with the lowest index. done pulses once at the end.
module masked_argmax_seq #(
    parameter int N     = 7,
    parameter int W     = 14,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     mask,
    input  logic [N*W-1:0]   vals,
    output logic             done,
    output logic [IDX_W-1:0] best_index,
    output logic [W-1:0]     best_value,
    output logic             found
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [N*W-1:0]      vals_reg;
    logic [N-1:0]        mask_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                found_reg;
    logic [IDX_W-1:0]    k_reg;
    logic [IDX_W-1:0]    best_idx_reg;
    logic signed [W-1:0] best_val_reg;

    logic signed [W-1:0] val_arr [N];
    logic signed [W-1:0] cur_val;
    logic                take;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign val_arr[gi] = vals_reg[gi*W +: W];
    end

    assign cur_val = val_arr[k_reg];
    assign take    = mask_reg[k_reg] && (!found_reg || (cur_val > best_val_reg));

    // Capture the operands on start, then evaluate one index per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vals_reg     <= '0;
            mask_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            found_reg    <= 1'b0;
            k_reg        <= '0;
            best_idx_reg <= '0;
            best_val_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                vals_reg     <= vals;
                mask_reg     <= mask;
                busy_reg     <= 1'b1;
                found_reg    <= 1'b0;
                k_reg        <= '0;
                best_idx_reg <= '0;
                best_val_reg <= MOST_NEG;
            end else if (busy_reg) begin
                if (take) begin
                    best_idx_reg <= k_reg;
                    best_val_reg <= cur_val;
                    found_reg    <= 1'b1;
                end
                if (k_reg == LAST_IDX) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end else begin
                    k_reg <= k_reg + 1'b1;
                end
            end
        end
    end

    assign done       = done_reg;
    assign best_index = best_idx_reg;
    assign best_value = best_val_reg;
    assign found      = found_reg;

endmodule

// File: rtl/nn_infer_ctrl.sv
// Inference controller: accepts a board request, quantises and registers the
// inputs, starts the network core, waits (with optional timeout) for its
// activations, picks the best legal column and holds the result until taken.
module nn_infer_ctrl
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS     = NN_NUM_INPUTS,
    parameter int DATA_WIDTH     = 32,
    parameter int IN_WIDTH       = 8,
    parameter int IN_SHIFT       = 5,
    parameter int NUM_OUTPUTS    = NN_NUM_OUTPUTS,
    parameter int ACT_WIDTH      = NN_ACT_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W         = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] inputs_packed,
    input  logic [NUM_OUTPUTS-1:0]           legal_mask,
    output logic                             core_start,
    output logic [NUM_INPUTS*IN_WIDTH-1:0]   core_inputs,
    input  logic                             core_done,
    input  logic [NUM_OUTPUTS*ACT_WIDTH-1:0] core_acts,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [IDX_W-1:0]                 res_index,
    output logic [ACT_WIDTH-1:0]             res_score,
    output logic [1:0]                       res_flags
);

    localparam int              TO_LIM       = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam int              CNT_W        = (TO_LIM > 1) ? $clog2(TO_LIM) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TO_LIM - 1);

    state_t                           state_reg;
    logic                             req_ready_reg;
    logic                             core_start_reg;
    logic                             res_valid_reg;
    logic [IDX_W-1:0]                 res_index_reg;
    logic [ACT_WIDTH-1:0]             res_score_reg;
    logic [1:0]                       res_flags_reg;
    logic [NUM_INPUTS*IN_WIDTH-1:0]   core_inputs_reg;
    logic [NUM_INPUTS*IN_WIDTH-1:0]   quant_next;
    logic [NUM_OUTPUTS-1:0]           mask_reg;
    logic [CNT_W-1:0]                 wait_cnt_reg;

    logic                             scan_start;
    logic                             am_done;
    logic [IDX_W-1:0]                 am_index;
    logic [ACT_WIDTH-1:0]             am_value;
    logic                             am_found;

    // Quantisation: shift each word left, keep the low IN_WIDTH bits.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_quant
        logic [DATA_WIDTH-1:0] shifted;
        logic                  unused_hi;
        assign shifted   = inputs_packed[gi*DATA_WIDTH +: DATA_WIDTH] << IN_SHIFT;
        assign unused_hi = ^shifted;
        assign quant_next[gi*IN_WIDTH +: IN_WIDTH] = shifted[IN_WIDTH-1:0];
    end

    // core_done only matters while waiting; it launches the argmax scan.
    assign scan_start = (state_reg == ST_WAIT) && core_done;

    masked_argmax_seq #(
        .N     (NUM_OUTPUTS),
        .W     (ACT_WIDTH),
        .IDX_W (IDX_W)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .start      (scan_start),
        .mask       (mask_reg),
        .vals       (core_acts),
        .done       (am_done),
        .best_index (am_index),
        .best_value (am_value),
        .found      (am_found)
    );

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            req_ready_reg   <= 1'b1;
            core_start_reg  <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_index_reg   <= '0;
            res_score_reg   <= '0;
            res_flags_reg   <= FLAGS_NONE;
            core_inputs_reg <= '0;
            mask_reg        <= '0;
            wait_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        core_inputs_reg <= quant_next;
                        mask_reg        <= legal_mask;
                        req_ready_reg   <= 1'b0;
                        core_start_reg  <= 1'b1;
                        wait_cnt_reg    <= '0;
                        state_reg       <= ST_START;
                    end
                end
                ST_START: begin
                    core_start_reg <= 1'b0;
                    state_reg      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        state_reg <= ST_SCAN;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_reg == TIMEOUT_LAST)) begin
                        res_valid_reg <= 1'b1;
                        res_index_reg <= '0;
                        res_score_reg <= '0;
                        res_flags_reg <= FLAGS_TIMEOUT;
                        state_reg     <= ST_RESULT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (am_done) begin
                        res_valid_reg <= 1'b1;
                        res_index_reg <= am_index;
                        res_score_reg <= am_value;
                        res_flags_reg <= am_found ? FLAGS_NONE : FLAGS_NO_LEGAL;
                        state_reg     <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    req_ready_reg  <= 1'b1;
                    core_start_reg <= 1'b0;
                    res_valid_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign core_start  = core_start_reg;
    assign core_inputs = core_inputs_reg;
    assign res_valid   = res_valid_reg;
    assign res_index   = res_index_reg;
    assign res_score   = res_score_reg;
    assign res_flags   = res_flags_reg;

endmodule

// File: doc/nn_infer_ctrl.md
NN_INFER_CTRL -- requirements
Module: nn_infer_ctrl

Interface
REQ-001 The block SHALL take parameter NUM_INPUTS, default 42, the number of board cells.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, the width of each packed input word.
REQ-003 The block SHALL take parameter IN_WIDTH, default 8, the width of each quantised core input.
REQ-004 The block SHALL take parameter IN_SHIFT, default 5, the left shift applied before truncation.
REQ-005 The block SHALL take parameter NUM_OUTPUTS, default 7, the number of columns/classes.
REQ-006 The block SHALL take parameter ACT_WIDTH, default 14, the signed activation width.
REQ-007 The block SHALL take parameter TIMEOUT_CYCLES, default 4096, the core-wait limit; 0 disables it.
REQ-008 The block SHALL have clk, input, 1 bit, the single clock; all logic SHALL be rising-edge.
REQ-009 The block SHALL have rst, input, 1 bit, a synchronous active-high reset.
REQ-010 The block SHALL have req_valid, input, 1 bit, request present.
REQ-011 The block SHALL have req_ready, output, 1 bit, request accepted when high with req_valid.
REQ-012 The block SHALL have inputs_packed, input, NUM_INPUTS*DATA_WIDTH bits, board words with word i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 The block SHALL have legal_mask, input, NUM_OUTPUTS bits, where bit k=1 means column k is playable.
REQ-014 The block SHALL have core_start, output, 1 bit, a one-cycle start pulse to the network core.
REQ-015 The block SHALL have core_inputs, output, NUM_INPUTS*IN_WIDTH bits, the registered quantised inputs.
REQ-016 The block SHALL have core_done, input, 1 bit, completion from the core.
REQ-017 The block SHALL have core_acts, input, NUM_OUTPUTS*ACT_WIDTH bits, signed activations, sampled while core_done is high.
REQ-018 The block SHALL have res_valid, output, 1 bit, result present.
REQ-019 The block SHALL have res_ready, input, 1 bit, result consumed.
REQ-020 The block SHALL have res_index, output, $clog2(NUM_OUTPUTS) bits, the chosen column.
REQ-021 The block SHALL have res_score, output, ACT_WIDTH bits, the signed winning activation.
REQ-022 The block SHALL have res_flags, output, 2 bits, where bit0 = timeout and bit1 = no_legal.

Function
REQ-023 FSM states SHALL be IDLE, START, WAIT, SCAN and RESULT.
REQ-024 req_ready SHALL be high only in IDLE.
REQ-025 On acceptance the block SHALL register core_inputs[i] = (word_i << IN_SHIFT)[IN_WIDTH-1:0], register legal_mask, and go to START.
REQ-026 START SHALL last exactly one cycle with core_start=1, then move to WAIT.
REQ-027 core_start SHALL be 0 in every other state.
REQ-028 In WAIT, core_done=1 SHALL capture core_acts and move to SCAN.
REQ-029 core_done SHALL be ignored outside WAIT.
REQ-030 The WAIT counter SHALL reach TIMEOUT_CYCLES without core_done, move to RESULT with index 0, score 0 and flags=01, and skip SCAN.
REQ-031 SCAN SHALL evaluate one index per cycle, k = 0..NUM_OUTPUTS-1, over exactly NUM_OUTPUTS cycles, skipping indices whose mask bit is 0.
REQ-032 The running best SHALL update only on strictly greater signed value, so ties resolve to the lowest index.
REQ-033 If no mask bit is set, the result SHALL be index 0, score = most-negative ACT_WIDTH value and flags=10.
REQ-034 res_valid SHALL rise the cycle after the last SCAN cycle.
REQ-035 Latency SHALL be done-sample edge + NUM_OUTPUTS + 1 cycles.
REQ-036 In RESULT, res_valid=1 and res_index, res_score and res_flags SHALL hold stable until res_ready=1, then the block SHALL return to IDLE.
REQ-037 Back-to-back operation SHALL give req_ready=1 in the cycle after the result handshake.
REQ-038 Inputs and legal_mask arriving after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-039 rst=1 SHALL force IDLE from any state, including mid-WAIT and mid-SCAN, with no result emitted.
REQ-040 Reset values SHALL be req_ready=1 (from the first post-reset cycle), core_start=0, res_valid=0, res_index=0, res_score=0, res_flags=00, core_inputs=0 and counters=0.
REQ-041 A core_done arriving after an aborted operation SHALL be ignored.

Structure
REQ-042 Shared package nn_pkg SHALL hold the state enum, the res_flags bit-position constants, and defaults NUM_INPUTS=42, NUM_OUTPUTS=7 and ACT_WIDTH=14.
REQ-043 There SHALL be one sub-module, masked_argmax_seq (sequential strict-greater masked argmax with start/done), instantiated by the FSM for SCAN.

Verification
REQ-044 Nominal: word0=3, others 0, mask=7F, core_done 10 cycles after core_start, acts {5,-2,9,9,0,1,-8} -> core_inputs[0]=0x60, res_index=2, score=9, flags=00, res_valid 8 cycles after done sample.
REQ-045 Masked: same acts, mask=0x7B -> res_index=3, score=9.
REQ-046 No legal move: mask=00 -> index 0, score=-8192, flags=10.
REQ-047 Timeout: TIMEOUT_CYCLES=16, core_done never asserted -> res_valid after 16 WAIT cycles with flags=01, index 0; a core_done pulse afterwards -> no effect.
REQ-048 Backpressure and reset: res_ready held 0 for 5 cycles -> outputs stable, then one handshake -> req_ready next cycle; rst asserted mid-SCAN -> IDLE next cycle, res_valid never rises.
